// File: rtl/branch_resolve_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_resolve_ctrl_pkg : shared encodings for EX-stage branch resolution
// Revision : 1.0
// ----------------------------------------------------------------------------
package branch_resolve_ctrl_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_EQ   = 3'b001,
    BR_NE   = 3'b010,
    BR_LT   = 3'b011,
    BR_GE   = 3'b100,
    BR_LTU  = 3'b101,
    BR_GEU  = 3'b110
  } br_op_e;

  typedef enum logic [1:0] {
    KIND_COND = 2'b00,
    KIND_JAL  = 2'b01,
    KIND_JALR = 2'b10,
    KIND_RSVD = 2'b11
  } br_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OPS = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_ctrl_target_calc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// br_target_calc : target, fall-through select and mispredict detection
// Revision : 1.0
// ----------------------------------------------------------------------------
module br_target_calc
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      br_kind,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            taken,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] next_pc,
  output logic            mispredict
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  always_comb begin
    jalr_sum = rs1_data + br_imm;
    if (br_kind == KIND_JALR) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else begin
      target = br_pc + br_imm;
    end
    next_pc    = taken ? target : (br_pc + XLEN'(4));
    // A not-taken outcome never checks the predicted target.
    mispredict = (taken != pred_taken) || (taken && (target != pred_target));
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_resolve_ctrl : EX-stage branch/JAL/JALR resolution, redirect, counters
// Revision : 1.0
// ----------------------------------------------------------------------------
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [1:0]       br_kind,
  input  logic [2:0]       br_op,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             ops_ready,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic [2:0]       cmp_op,
  output logic [XLEN-1:0]  cmp_a,
  output logic [XLEN-1:0]  cmp_b,
  input  logic             cmp_taken,
  output logic             ex_stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             br_done,
  output logic             br_taken_o,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispred
);

  state_e           state_q, state_d;
  logic             redir_q, redir_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             br_done_q, br_done_d;
  logic             br_taken_q, br_taken_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

  logic             accept;
  logic             is_cond;
  logic             taken;
  logic             resolve;
  logic [XLEN-1:0]  next_pc;
  logic             mispredict;

  br_target_calc #(.XLEN(XLEN)) u_target_calc (
    .br_kind     (br_kind),
    .br_pc       (br_pc),
    .br_imm      (br_imm),
    .rs1_data    (rs1_data),
    .taken       (taken),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .next_pc     (next_pc),
    .mispredict  (mispredict)
  );

  assign cmp_a = rs1_data;
  assign cmp_b = rs2_data;

  always_comb begin
    // Wrong-path instructions arrive while REDIRECT is pending; never accept them.
    accept   = br_valid && (br_kind != KIND_RSVD) && (state_q != ST_REDIRECT);
    is_cond  = (br_kind == KIND_COND);
    taken    = is_cond ? cmp_taken : 1'b1;
    resolve  = accept && ops_ready;
    cmp_op   = (accept && is_cond) ? br_op : BR_NONE;
    ex_stall = accept && !ops_ready;

    state_d       = state_q;
    redir_d       = redir_q;
    redirect_pc_d = redirect_pc_q;
    br_done_d     = 1'b0;
    br_taken_d    = 1'b0;
    cnt_branch_d  = cnt_branch_q;
    cnt_mispred_d = cnt_mispred_q;

    case (state_q)
      ST_IDLE, ST_WAIT_OPS: begin
        if (resolve) begin
          br_done_d  = 1'b1;
          br_taken_d = taken;
          if (!(&cnt_branch_q)) begin
            cnt_branch_d = cnt_branch_q + CNT_W'(1);
          end
          if (mispredict) begin
            if (!(&cnt_mispred_q)) begin
              cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
            end
            redirect_pc_d = next_pc;
            redir_d       = 1'b1;
            state_d       = ST_REDIRECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (accept) begin
          state_d = ST_WAIT_OPS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          redir_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        redir_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      redir_q       <= 1'b0;
      redirect_pc_q <= '0;
      br_done_q     <= 1'b0;
      br_taken_q    <= 1'b0;
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      state_q       <= state_d;
      redir_q       <= redir_d;
      redirect_pc_q <= redirect_pc_d;
      br_done_q     <= br_done_d;
      br_taken_q    <= br_taken_d;
      cnt_branch_q  <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign flush          = redir_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_done        = br_done_q;
  assign br_taken_o     = br_taken_q;
  assign cnt_branch     = cnt_branch_q;
  assign cnt_mispred    = cnt_mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_branch_resolve_ctrl : scoreboard bench for branch_resolve_ctrl
// Revision : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  localparam int XLEN    = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic             br_valid;
  logic [1:0]       br_kind;
  logic [2:0]       br_op;
  logic [XLEN-1:0]  br_pc, br_imm, rs1_data, rs2_data;
  logic             ops_ready, pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic [2:0]       cmp_op;
  logic [XLEN-1:0]  cmp_a, cmp_b;
  logic             cmp_taken;
  logic             ex_stall, flush, redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_ready;
  logic             br_done, br_taken_o;
  logic [CNT_W-1:0] cnt_branch, cnt_mispred;

  typedef struct {
    logic            taken;
    logic            mis;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next;
    logic [CNT_W-1:0] cb;
    logic [CNT_W-1:0] cm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cb = 0;
  int   exp_cm = 0;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_kind(br_kind), .br_op(br_op),
    .br_pc(br_pc), .br_imm(br_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ops_ready(ops_ready), .pred_taken(pred_taken), .pred_target(pred_target),
    .cmp_op(cmp_op), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_taken(cmp_taken),
    .ex_stall(ex_stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .br_done(br_done), .br_taken_o(br_taken_o),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_cmp(input logic [2:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    case (op)
      BR_EQ:   return a == b;
      BR_NE:   return a != b;
      BR_LT:   return $signed(a) < $signed(b);
      BR_GE:   return $signed(a) >= $signed(b);
      BR_LTU:  return a < b;
      BR_GEU:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // External comparator the DUT drives through cmp_*.
  assign cmp_taken = ref_cmp(cmp_op, cmp_a, cmp_b);

  function automatic exp_t model(input logic [1:0] kind, input logic [2:0] op,
                                 input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic pt, input logic [XLEN-1:0] ptg);
    exp_t e;
    logic [XLEN-1:0] s;
    e.taken = (kind == KIND_COND) ? ref_cmp(op, a, b) : 1'b1;
    s = a + imm;
    e.target = (kind == KIND_JALR) ? (s & ~64'd1) : (pc + imm);
    e.next = e.taken ? e.target : (pc + 64'd4);
    e.mis = (e.taken != pt) || (e.taken && (e.target != ptg));
    e.cb = '0;
    e.cm = '0;
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input exp_t e_in);
    exp_t e;
    e = e_in;
    if (exp_cb < CNT_MAX) exp_cb++;
    if (e.mis && exp_cm < CNT_MAX) exp_cm++;
    e.cb = exp_cb[CNT_W-1:0];
    e.cm = exp_cm[CNT_W-1:0];
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (br_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", {63'd0, br_done}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("br_taken_o", {63'd0, br_taken_o}, {63'd0, mon_e.taken});
        check_val("cnt_branch", {60'd0, cnt_branch}, {60'd0, mon_e.cb});
        check_val("cnt_mispred", {60'd0, cnt_mispred}, {60'd0, mon_e.cm});
        check_val("redirect_valid_done", {63'd0, redirect_valid}, {63'd0, mon_e.mis});
        if (mon_e.mis) begin
          check_val("redirect_pc_done", redirect_pc, mon_e.next);
          check_val("flush_done", {63'd0, flush}, 64'd1);
        end
      end
    end
  end

  task automatic set_br(input logic [1:0] kind, input logic [2:0] op, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic pt, input logic [XLEN-1:0] ptg);
    br_kind = kind; br_op = op; br_pc = pc; br_imm = imm;
    rs1_data = a; rs2_data = b; pred_taken = pt; pred_target = ptg;
  endtask

  // Presents a ready branch for one cycle; br_valid is left high afterwards.
  task automatic resolve_br(input logic [1:0] kind, input logic [2:0] op, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] imm, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic pt, input logic [XLEN-1:0] ptg);
    exp_t e;
    e = model(kind, op, pc, imm, a, b, pt, ptg);
    set_br(kind, op, pc, imm, a, b, pt, ptg);
    br_valid = 1'b1; ops_ready = 1'b1;
    push_exp(e);
    @(negedge clk);
    check_val("ex_stall_resolve", {63'd0, ex_stall}, 64'd0);
    check_val("cmp_op", {61'd0, cmp_op}, {61'd0, (kind == KIND_COND) ? op : 3'b000});
    @(posedge clk); #1;
  endtask

  task automatic finish_redirect(input int hold, input logic [XLEN-1:0] pc);
    redirect_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("flush_hold", {63'd0, flush}, 64'd1);
      check_val("redirect_valid_hold", {63'd0, redirect_valid}, 64'd1);
      check_val("redirect_pc_hold", redirect_pc, pc);
      check_val("ex_stall_redirect", {63'd0, ex_stall}, 64'd0);
      @(posedge clk); #1;
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    check_val("redirect_valid_exit", {63'd0, redirect_valid}, 64'd1);
    check_val("redirect_pc_exit", redirect_pc, pc);
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    check_val("flush_after", {63'd0, flush}, 64'd0);
    check_val("redirect_valid_after", {63'd0, redirect_valid}, 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    br_valid = 1'b0; ops_ready = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    check_val("sb_drain", 64'(sb_q.size()), 64'd0);
  endtask

  logic [XLEN-1:0] r_pc, r_imm, r_a, r_b;
  logic [1:0]      r_kind;
  logic [2:0]      r_op;
  exp_t            r_e;

  initial begin
    rst = 1'b1; br_valid = 1'b0; ops_ready = 1'b0; redirect_ready = 1'b0;
    set_br(2'b00, 3'b000, '0, '0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_flush", {63'd0, flush}, 64'd0);
    check_val("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check_val("rst_redirect_pc", redirect_pc, 64'd0);
    check_val("rst_br_done", {63'd0, br_done}, 64'd0);
    check_val("rst_cnt_branch", {60'd0, cnt_branch}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // BEQ taken, predicted not-taken
    resolve_br(KIND_COND, BR_EQ, 64'h100, 64'h40, 64'd5, 64'd5, 1'b0, 64'd0);
    br_valid = 1'b0;
    finish_redirect(0, 64'h140);
    idle_cycles(1);

    // BLTU not taken, then BLT taken and predicted, back to back
    resolve_br(KIND_COND, BR_LTU, 64'h200, 64'h80, '1, 64'd1, 1'b0, 64'd0);
    resolve_br(KIND_COND, BR_LT, 64'h204, 64'h80, '1, 64'd1, 1'b1, 64'h284);
    idle_cycles(1);

    // JALR correct target, then off-by-one predicted target
    resolve_br(KIND_JALR, BR_NONE, 64'h300, 64'h10, 64'h2001, 64'd0, 1'b1, 64'h2010);
    resolve_br(KIND_JALR, BR_NONE, 64'h304, 64'h10, 64'h2001, 64'd0, 1'b1, 64'h2011);
    br_valid = 1'b0;
    finish_redirect(0, 64'h2010);
    idle_cycles(1);

    // Operand stall for 3 cycles
    r_e = model(KIND_COND, BR_NE, 64'h400, 64'h20, 64'd1, 64'd2, 1'b1, 64'h420);
    set_br(KIND_COND, BR_NE, 64'h400, 64'h20, 64'd1, 64'd2, 1'b1, 64'h420);
    br_valid = 1'b1; ops_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("ex_stall_wait", {63'd0, ex_stall}, 64'd1);
      @(posedge clk); #1;
    end
    ops_ready = 1'b1;
    push_exp(r_e);
    @(negedge clk);
    check_val("ex_stall_release", {63'd0, ex_stall}, 64'd0);
    @(posedge clk); #1;
    idle_cycles(1);

    // br_valid dropping in WAIT_OPS has no effect
    br_valid = 1'b1; ops_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    idle_cycles(2);

    // Reserved kind is ignored
    set_br(KIND_RSVD, BR_EQ, 64'h500, 64'h4, 64'd0, 64'd0, 1'b0, 64'd0);
    br_valid = 1'b1; ops_ready = 1'b0;
    @(negedge clk);
    check_val("rsvd_stall", {63'd0, ex_stall}, 64'd0);
    check_val("rsvd_cmp_op", {61'd0, cmp_op}, 64'd0);
    @(posedge clk); #1;
    ops_ready = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2);

    // Mispredict held 3 cycles with wrong-path br_valid; exit-cycle branch dropped
    resolve_br(KIND_JAL, BR_NONE, 64'h600, 64'h100, 64'd0, 64'd0, 1'b0, 64'd0);
    set_br(KIND_COND, BR_EQ, 64'h604, 64'h8, 64'd3, 64'd3, 1'b0, 64'd0);
    br_valid = 1'b1; ops_ready = 1'b1;
    finish_redirect(2, 64'h700);
    resolve_br(KIND_COND, BR_EQ, 64'h700, 64'h8, 64'd3, 64'd3, 1'b1, 64'h708);
    idle_cycles(1);

    // Address wrap-around
    resolve_br(KIND_JAL, BR_NONE, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd0, 64'd0, 1'b0, 64'd0);
    br_valid = 1'b0;
    finish_redirect(1, 64'h10);
    resolve_br(KIND_COND, BR_NE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'd7, 64'd7, 1'b1, 64'd0);
    br_valid = 1'b0;
    finish_redirect(0, 64'h0);
    idle_cycles(1);

    // Asynchronous reset in the second REDIRECT cycle
    resolve_br(KIND_JAL, BR_NONE, 64'h800, 64'h40, 64'd0, 64'd0, 1'b0, 64'd0);
    br_valid = 1'b0;
    @(posedge clk); #1;
    check_val("redirect_valid_pre_rst", {63'd0, redirect_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_mid_flush", {63'd0, flush}, 64'd0);
    check_val("rst_mid_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check_val("rst_mid_redirect_pc", redirect_pc, 64'd0);
    check_val("rst_mid_cnt_branch", {60'd0, cnt_branch}, 64'd0);
    check_val("rst_mid_cnt_mispred", {60'd0, cnt_mispred}, 64'd0);
    exp_cb = 0; exp_cm = 0;
    check_val("sb_at_rst", 64'(sb_q.size()), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    resolve_br(KIND_COND, BR_GEU, 64'h900, 64'h10, 64'd9, 64'd2, 1'b1, 64'h910);
    idle_cycles(1);

    // Back-to-back correctly predicted random branches, saturating cnt_branch
    for (int i = 0; i < 20; i++) begin
      r_kind = 2'($urandom_range(0, 2));
      r_op   = 3'($urandom_range(1, 6));
      r_pc   = {$urandom, $urandom} & ~64'd3;
      r_imm  = {{52{1'b0}}, 12'($urandom)} - 64'h800;
      r_a    = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3)) : -64'($urandom_range(1, 3));
      r_b    = 64'($urandom_range(0, 3));
      r_e    = model(r_kind, r_op, r_pc, r_imm, r_a, r_b, 1'b0, '0);
      resolve_br(r_kind, r_op, r_pc, r_imm, r_a, r_b, r_e.taken, r_e.target);
    end
    idle_cycles(1);

    // Mispredict counter saturation
    for (int i = 0; i < 17; i++) begin
      resolve_br(KIND_JAL, BR_NONE, 64'hA00, 64'h40, 64'd0, 64'd0, 1'b1, 64'hA44);
      br_valid = 1'b0;
      finish_redirect(0, 64'hA40);
    end
    idle_cycles(2);
    check_val("final_cnt_branch", {60'd0, cnt_branch}, 64'(CNT_MAX));
    check_val("final_cnt_mispred", {60'd0, cnt_mispred}, 64'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Execute-stage branch resolution controller for the pipelined core. It sequences the shared branch comparator for conditional branches, JAL and JALR. It checks each resolved outcome and target against the fetch-stage prediction and stalls EX while operands are not ready. On a misprediction it holds a flush plus redirect handshake toward IF until IF accepts it. It also keeps saturating branch and mispredict counters.

## Interface
- XLEN, 64, data and PC width
- CNT_W, 32, performance counter width
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- br_valid  in  1  EX holds a control-transfer instruction
- br_kind  in  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved
- br_op  in  3  compare op: 001 EQ, 010 NE, 011 LT, 100 GE, 101 LTU, 110 GEU, 000 none
- br_pc  in  XLEN  PC of the instruction
- br_imm  in  XLEN  sign-extended offset
- rs1_data, rs2_data  in  XLEN  forwarded operands
- ops_ready  in  1  both operands valid this cycle
- pred_taken  in  1  fetch prediction
- pred_target  in  XLEN  predicted target
- cmp_op  out  3  op to the comparator
- cmp_a, cmp_b  out  XLEN  comparator operands (equal to rs1_data and rs2_data)
- cmp_taken  in  1  combinational comparator result
- ex_stall  out  1  hold EX and all older stages
- flush  out  1  kill IF/ID and ID/EX contents
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  XLEN  corrected fetch PC
- redirect_ready  in  1  IF accepts the redirect
- br_done  out  1  one-cycle pulse per resolved instruction
- br_taken_o  out  1  actual outcome, valid with br_done
- cnt_branch, cnt_mispred  out  CNT_W  resolved and mispredicted counts

## Operation
- States:
  - IDLE
  - WAIT_OPS
  - REDIRECT
- Reset values: state IDLE; ex_stall, flush, redirect_valid, br_done and br_taken_o are 0; redirect_pc is 0; counters are 0.
- Accepted instruction: br_valid=1 and br_kind≠11, in IDLE or WAIT_OPS. br_kind=11 is ignored: no stall, no done pulse, no count.
- cmp_op = br_op only for an accepted cond branch; otherwise 000.
- IDLE with an accepted instruction:
  - ops_ready=0: ex_stall=1, go to WAIT_OPS.
  - ops_ready=1: resolve in the same cycle.
- WAIT_OPS:
  - ex_stall=1 every cycle while ops_ready=0.
  - Resolves in the first cycle ops_ready=1; ex_stall=0 in that cycle.
  - br_valid dropping while in WAIT_OPS returns the block to IDLE with no effect.
- Resolve:
  - taken = cmp_taken for a cond branch, 1 for JAL and JALR.
  - target = br_pc+br_imm for a cond branch or JAL; (rs1_data+br_imm) with bit0 cleared for JALR.
  - next = taken ? target : br_pc+4.
  - All additions are modulo 2^XLEN; wrap-around is legal.
  - mispredict = (taken≠pred_taken) or (taken and target≠pred_target).
  - br_done=1 and br_taken_o=taken (registered, visible the next cycle).
  - cnt_branch increments; cnt_mispred increments on mispredict. Both saturate at all-ones.
  - On mispredict: latch redirect_pc=next and go to REDIRECT. Otherwise stay in IDLE.
- REDIRECT:
  - flush=1 and redirect_valid=1 every cycle.
  - br_valid is ignored because it carries wrong-path instructions; no resolve, no count.
  - redirect_ready=1 completes the transfer; the next state is IDLE with flush=0.
  - redirect_pc is stable while redirect_valid=1.

## Timing
- Resolve cycle: combinational through the comparator; only cmp_op and ex_stall are combinational outputs.
- br_done, br_taken_o, flush, redirect_valid and redirect_pc are registered: they appear in cycle N+1 after resolve in cycle N.
- Minimum redirect occupancy is 1 cycle (redirect_ready=1 in the first REDIRECT cycle).
- Back-to-back correctly predicted branches resolve one per cycle with no bubble.
- A branch that arrives in the cycle REDIRECT exits (redirect_ready=1) is dropped; the first accepted branch is in the following cycle, in IDLE.
- Asynchronous rst at any point, including mid-REDIRECT or mid-WAIT_OPS, immediately forces all reset values. A pending redirect is abandoned.

## Structure
- Shared core package holds:
  - br_op encodings (BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU)
  - br_kind encodings
  - the state enum
- Sub-module br_target_calc (combinational) computes target, next and mispredict. The FSM and counters stay in the top module.
- The comparator is external and connected through the cmp_* ports.

## Test plan
- BEQ, rs1=rs2=5, pred_taken=0, br_pc=0x100, br_imm=0x40 → br_done next cycle, br_taken_o=1, redirect_pc=0x140, flush=1 until redirect_ready, cnt_mispred=1.
- BLTU, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1, pred_taken=0 → not taken, no redirect, cnt_branch=1, cnt_mispred=0. Same operands with BLT → taken.
- JALR, rs1=0x2001, br_imm=0x10, pred_target=0x2010 → target 0x2010, no redirect. With pred_target=0x2011 → redirect to 0x2010.
- ops_ready low for 3 cycles → ex_stall high for exactly 3 cycles; resolve and br_done follow the cycle ops_ready rises.
- Mispredict with redirect_ready low for 2 cycles while br_valid=1 → redirect_valid held 3 cycles, redirect_pc stable, counters unchanged by the wrong-path br_valid.
- rst asserted in the second REDIRECT cycle → flush and redirect_valid drop immediately, counters are 0, and a branch accepted after reset release resolves normally.
